// File: rtl/mult_div_unit_if.sv
// Purpose: bundles the pipeline <-> mult/div unit signals (operands, HI/LO access, status).
// Latency: pure wiring, no storage.
// Backpressure: none here; the pipeline observes busy and stalls MFHI/MFLO itself.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] read_data_1;
  logic [WIDTH-1:0] read_data_2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             rd_sel;
  logic [WIDTH-1:0] read_data;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Pipeline side: launches ops, writes/reads HI/LO.
  modport master (
    output start, op, read_data_1, read_data_2, hi_we, lo_we, wdata, rd_sel,
    input  read_data, busy, done, div_zero
  );

  // Unit side.
  modport slave (
    input  start, op, read_data_1, read_data_2, hi_we, lo_we, wdata, rd_sel,
    output read_data, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Purpose: iterative shift-add multiplier / restoring divider owning HI/LO; SIGNED_OPS_EN enables signed MULT/DIV.
// Latency: WIDTH+1 cycles start->done (1 cycle for divide by zero); HI/LO reads are combinational.
// Backpressure: none; start and MTHI/MTLO writes are dropped while busy=1, caller must wait for done.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // wa: product upper half / partial remainder; wb: multiplier / quotient-dividend.
  logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
  // opb: multiplicand (mult) or divisor (div) magnitude.
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_prod_q, neg_prod_d;  // negate product / quotient in FIX
  logic             neg_rem_q, neg_rem_d;    // negate remainder in FIX
  logic             dz_q, dz_d;              // divide-by-zero result waiting in FIX
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             signed_op, sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b, addend;
  logic [WIDTH:0]   msum, dtrial;
  logic [2*WIDTH-1:0] prod_neg;

`ifdef SIGNED_OPS_EN
  assign signed_op = mdu.op[0];
`else
  // op[0] has no effect in an unsigned-only build; the AND folds it away.
  assign signed_op = mdu.op[0] & 1'b0;
`endif

  assign sgn_a  = signed_op & mdu.read_data_1[WIDTH-1];
  assign sgn_b  = signed_op & mdu.read_data_2[WIDTH-1];
  assign mag_a  = sgn_a ? -mdu.read_data_1 : mdu.read_data_1;
  assign mag_b  = sgn_b ? -mdu.read_data_2 : mdu.read_data_2;

  // One multiply step adds the multiplicand when the multiplier LSB is set, then shifts right.
  assign addend   = wb_q[0] ? opb_q : '0;
  assign msum     = {1'b0, wa_q} + {1'b0, addend};
  // One divide step: trial-subtract the divisor from the remainder shifted left by one dividend bit.
  assign dtrial   = {wa_q, wb_q[WIDTH-1]} - {1'b0, opb_q};
  assign prod_neg = -{wa_q, wb_q};

  assign mdu.read_data = mdu.rd_sel ? hi_q : lo_q;
  assign mdu.busy      = (state_q != IDLE);
  assign mdu.done      = done_q;
  assign mdu.div_zero  = div_zero_q;

  // Next-state and datapath: capture in IDLE, iterate in RUN, sign-fix and commit in FIX.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wa_d       = wa_q;
    wb_d       = wb_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_prod_d = neg_prod_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu.start) begin
          is_div_d = mdu.op[1];
          cnt_d    = '0;
          if (mdu.op[1] && (mdu.read_data_2 == '0)) begin
            // Divide by zero skips iteration; FIX commits HI=rs, LO=all ones unchanged.
            wa_d       = mdu.read_data_1;
            wb_d       = '1;
            dz_d       = 1'b1;
            neg_prod_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = FIX;
          end else begin
            dz_d       = 1'b0;
            neg_prod_d = sgn_a ^ sgn_b;
            neg_rem_d  = sgn_a & mdu.op[1];
            wa_d       = '0;
            wb_d       = mdu.op[1] ? mag_a : mag_b;
            opb_d      = mdu.op[1] ? mag_b : mag_a;
            state_d    = RUN;
          end
        end else begin
          // MTHI/MTLO only land when no op is being launched.
          if (mdu.hi_we) hi_d = mdu.wdata;
          if (mdu.lo_we) lo_d = mdu.wdata;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!dtrial[WIDTH]) begin
            wa_d = dtrial[WIDTH-1:0];
            wb_d = {wb_q[WIDTH-2:0], 1'b1};
          end else begin
            wa_d = {wa_q[WIDTH-2:0], wb_q[WIDTH-1]};
            wb_d = {wb_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          wa_d = msum[WIDTH:1];
          wb_d = {msum[0], wb_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          hi_d       = wa_q;
          lo_d       = wb_q;
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = neg_rem_q  ? -wa_q : wa_q;
          lo_d = neg_prod_q ? -wb_q : wb_q;
        end else begin
          {hi_d, lo_d} = neg_prod_q ? prod_neg : {wa_q, wb_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wa_q       <= wa_d;
      wb_q       <= wb_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_prod_q <= neg_prod_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: directed + random checks of mult_div_unit against an arithmetic reference model.
// Latency: expects done WIDTH+1 cycles after start (1 cycle on divide by zero).
// Backpressure: exercises dropped start/MTHI while busy and start-vs-write priority.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mult_div_unit_if #(.WIDTH(32)) mif ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, truncating division, remainder follows dividend sign.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic        sg;
    longint      sa, sb, q, r;
    logic [63:0] p;
`ifdef SIGNED_OPS_EN
    sg = o[0];
`else
    sg = 1'b0;
`endif
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    dz = 1'b0;
    if (!o[1]) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
      h  = a;
      l  = 32'hFFFF_FFFF;
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = 64'(q);
      l = p[31:0];
      p = 64'(r);
      h = p[31:0];
    end
  endfunction

  task automatic check_regs(input string tag);
    mif.rd_sel = 1'b1;
    #1 chk({tag, ".hi"}, mif.read_data, cur_hi);
    mif.rd_sel = 1'b0;
    #1 chk({tag, ".lo"}, mif.read_data, cur_lo);
  endtask

  // Drives start for one edge; returns #1 after edge E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic we);
    @(negedge clk);
    mif.start = 1'b1; mif.op = o; mif.read_data_1 = a; mif.read_data_2 = b;
    mif.hi_we = we; mif.lo_we = we; mif.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mif.start = 1'b0; mif.hi_we = 1'b0; mif.lo_we = 1'b0;
  endtask

  // Waits (bounded) for done, c0 = edges already elapsed since E0, then checks everything.
  task automatic wait_done(input string tag, input int c0, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    logic [31:0] eh, el;
    logic        edz;
    model(o, a, b, eh, el, edz);
    cyc = c0;
    while (!mif.done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), edz ? 32'd1 : 32'd33);
    chk({tag, ".done"}, 32'(mif.done), 32'd1);
    chk({tag, ".div_zero"}, 32'(mif.div_zero), 32'(edz));
    chk({tag, ".busy"}, 32'(mif.busy), 32'd0);
    cur_hi = eh;
    cur_lo = el;
    check_regs(tag);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b, 1'b0);
    chk({tag, ".busy_e0"}, 32'(mif.busy), 32'd1);
    wait_done(tag, 0, o, a, b);
  endtask

  task automatic mt(input string tag, input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mif.hi_we = h; mif.lo_we = l; mif.wdata = d;
    @(posedge clk);
    #1;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0;
    if (h) cur_hi = d;
    if (l) cur_lo = d;
    check_regs(tag);
  endtask

  initial begin
    mif.start = 1'b0; mif.op = 2'b00; mif.read_data_1 = '0; mif.read_data_2 = '0;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.wdata = '0; mif.rd_sel = 1'b0;

    // Reset state.
    #12;
    chk("rst.busy", 32'(mif.busy), 32'd0);
    chk("rst.done", 32'(mif.done), 32'd0);
    chk("rst.div_zero", 32'(mif.div_zero), 32'd0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic corners.
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0);
    run_op("div_m9_0", 2'b11, 32'hFFFF_FFF7, 32'd0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_7_m3", 2'b01, 32'd7, 32'hFFFF_FFFD);

    // MTHI/MTLO, separately and together.
    mt("mtlo", 1'b0, 1'b1, 32'h0000_1234);
    mt("mthi", 1'b1, 1'b0, 32'h5555_AAAA);
    mt("mtboth", 1'b1, 1'b1, 32'hCAFE_F00D);
    run_op("mult_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // start + write in the same idle cycle: the write is dropped.
    launch(2'b00, 32'd3, 32'd4, 1'b1);
    wait_done("start_vs_we", 0, 2'b00, 32'd3, 32'd4);

    // Mid-op start and MTHI are ignored; read_data holds committed values while running.
    launch(2'b00, 32'h0001_0000, 32'h0003_0000, 1'b0);
    repeat (4) @(posedge clk);
    #1 check_regs("run_hold");
    repeat (5) @(posedge clk);
    @(negedge clk);
    mif.start = 1'b1; mif.op = 2'b10; mif.read_data_1 = 32'd100; mif.read_data_2 = 32'd7;
    mif.hi_we = 1'b1; mif.wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    mif.start = 1'b0; mif.hi_we = 1'b0;
    wait_done("busy_ignore", 10, 2'b00, 32'h0001_0000, 32'h0003_0000);

    // Asynchronous reset mid-op, then a fresh op.
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(mif.busy), 32'd0);
    cur_hi = '0;
    cur_lo = '0;
    check_regs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.done", 32'(mif.done), 32'd0);
    run_op("after_rst", 2'b11, 32'd100, 32'hFFFF_FFF9);

    // Randomised ops; divisor sometimes forced to zero.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      run_op($sformatf("rand%0d", i), o, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
